motor_step_sequencer: RTL and testbench

Coordinated 4-axis step/direction sequencer that turns the four 16-bit motor command words (motora, motorb, motorx, motory) into synchronized step pulses. A move is a straight line in 4-axis space. The axis with the most steps sets the step rate, and the other axes are interleaved by Bresenham error accumulation. The block sits between the soft-processor PIO outputs and the motor driver pins, and hands busy/done/aborted status back to a PIO input.

---
 rtl/motor_step_sequencer_if.sv | 26 ++
 rtl/motor_step_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_motor_step_sequencer.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/motor_step_sequencer_if.sv
// Command/status bundle between the PIO side (master) and the step sequencer (slave).
interface motor_step_sequencer_if;
  logic [15:0] motora_cmd;
  logic [15:0] motorb_cmd;
  logic [15:0] motorx_cmd;
  logic [15:0] motory_cmd;
  logic        start;
  logic        abort;
  logic [3:0]  step;
  logic [3:0]  dir;
  logic [3:0]  en;
  logic        busy;
  logic        done;
  logic        aborted;
  logic [14:0] remaining;

  modport master (
    output motora_cmd, motorb_cmd, motorx_cmd, motory_cmd, start, abort,
    input  step, dir, en, busy, done, aborted, remaining
  );

  modport slave (
    input  motora_cmd, motorb_cmd, motorx_cmd, motory_cmd, start, abort,
    output step, dir, en, busy, done, aborted, remaining
  );
endinterface

// File: rtl/motor_step_sequencer.sv
// Coordinated 4-axis step/direction sequencer. The longest axis sets the major
// step rate; the other axes are interleaved with Bresenham error accumulators.
// Every output is a register; the FSM computes next values combinationally.
module motor_step_sequencer #(
  parameter int STEP_DIV = 50000,
  parameter int PULSE_W  = 50
) (
  input  logic                  clk_clk,
  input  logic                  reset_reset,
  motor_step_sequencer_if.slave bus
);

  localparam logic [15:0] LP_CNT_MAX = 16'(STEP_DIV - 1);
  localparam logic [15:0] LP_PW_LOAD = 16'(PULSE_W - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_RUN, ST_DONE} state_t;

  state_t            r_state, w_state_next;
  logic [3:0][14:0]  r_mag, w_mag_next;
  logic [3:0]        r_dirbits, w_dirbits_next;
  logic [14:0]       r_n, w_n_next;
  logic [3:0][15:0]  r_err, w_err_next;
  logic [15:0]       r_cnt, w_cnt_next;
  logic [15:0]       r_pw, w_pw_next;
  logic [3:0]        r_step, w_step_next;
  logic [3:0]        r_dir, w_dir_next;
  logic [3:0]        r_en, w_en_next;
  logic              r_busy, w_busy_next;
  logic              r_done, w_done_next;
  logic              r_aborted, w_aborted_next;
  logic [14:0]       r_rem, w_rem_next;

  logic [3:0][15:0]  w_cmd;
  logic [3:0][15:0]  w_err_sum;
  logic [3:0][15:0]  w_err_wrap;
  logic [3:0]        w_err_hit;
  logic [14:0]       w_n_max;
  logic              w_major;

  assign w_cmd = {bus.motory_cmd, bus.motorx_cmd, bus.motorb_cmd, bus.motora_cmd};

  // Per-axis Bresenham update: add m_i, wrap by N and flag a pulse when it wraps.
  // err stays below N before the add, so the 16-bit sum cannot overflow.
  for (genvar gi = 0; gi < 4; gi++) begin : g_axis
    assign w_err_sum[gi]  = r_err[gi] + {1'b0, r_mag[gi]};
    assign w_err_hit[gi]  = (w_err_sum[gi] >= {1'b0, r_n});
    assign w_err_wrap[gi] = w_err_hit[gi] ? (w_err_sum[gi] - {1'b0, r_n}) : w_err_sum[gi];
  end

  // Longest axis of the latched move; it defines the number of major steps.
  always_comb begin
    w_n_max = r_mag[0];
    for (int i = 1; i < 4; i++) begin
      if (r_mag[i] > w_n_max) w_n_max = r_mag[i];
    end
  end

  assign w_major = (r_state == ST_RUN) && (r_cnt == LP_CNT_MAX) && (r_rem != '0);

  // Next-state and next-output logic; the pulse timer runs in every state.
  always_comb begin
    w_state_next   = r_state;
    w_mag_next     = r_mag;
    w_dirbits_next = r_dirbits;
    w_n_next       = r_n;
    w_err_next     = r_err;
    w_cnt_next     = r_cnt;
    w_pw_next      = r_pw;
    w_step_next    = r_step;
    w_dir_next     = r_dir;
    w_en_next      = r_en;
    w_busy_next    = r_busy;
    w_done_next    = 1'b0;
    w_aborted_next = 1'b0;
    w_rem_next     = r_rem;

    // Step pulses stay high until the width timer has run out.
    if (r_pw != '0) begin
      w_pw_next = r_pw - 16'd1;
    end else begin
      w_step_next = '0;
    end

    if (bus.abort && (r_state == ST_LOAD || r_state == ST_RUN)) begin
      // Abort truncates any pulse in flight and drops the move.
      w_step_next    = '0;
      w_pw_next      = '0;
      w_en_next      = '0;
      w_busy_next    = 1'b0;
      w_aborted_next = 1'b1;
      w_rem_next     = '0;
      w_state_next   = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start && !bus.abort) begin
            for (int i = 0; i < 4; i++) begin
              w_mag_next[i]     = w_cmd[i][14:0];
              w_dirbits_next[i] = w_cmd[i][15];
            end
            w_state_next = ST_LOAD;
          end
        end
        ST_LOAD: begin
          w_n_next = w_n_max;
          for (int i = 0; i < 4; i++) begin
            w_err_next[i] = {1'b0, w_n_max} >> 1;
            w_en_next[i]  = (r_mag[i] != '0);
          end
          w_dir_next   = r_dirbits;
          w_rem_next   = w_n_max;
          w_busy_next  = 1'b1;
          w_cnt_next   = '0;
          w_state_next = (w_n_max == '0) ? ST_DONE : ST_RUN;
        end
        ST_RUN: begin
          w_cnt_next = (r_cnt == LP_CNT_MAX) ? '0 : r_cnt + 16'd1;
          if (w_major) begin
            w_err_next  = w_err_wrap;
            w_step_next = w_err_hit;
            w_pw_next   = LP_PW_LOAD;
            w_rem_next  = r_rem - 15'd1;
            // A one-cycle pulse ends immediately, so finish on the last step itself.
            if (PULSE_W == 1 && r_rem == 15'd1) w_state_next = ST_DONE;
          end else if (PULSE_W > 1 && r_rem == '0 && r_pw == 16'd1) begin
            // DONE lines up with the final cycle of the last pulse so that done
            // rises on the same edge that ends the pulse.
            w_state_next = ST_DONE;
          end
        end
        ST_DONE: begin
          w_done_next  = 1'b1;
          w_busy_next  = 1'b0;
          w_en_next    = '0;
          w_state_next = ST_IDLE;
        end
        default: w_state_next = ST_IDLE;
      endcase
    end
  end

  // State and datapath registers; reset clears every output at once.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      r_state   <= ST_IDLE;
      r_mag     <= '0;
      r_dirbits <= '0;
      r_n       <= '0;
      r_err     <= '0;
      r_cnt     <= '0;
      r_pw      <= '0;
      r_step    <= '0;
      r_dir     <= '0;
      r_en      <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
      r_rem     <= '0;
    end else begin
      r_state   <= w_state_next;
      r_mag     <= w_mag_next;
      r_dirbits <= w_dirbits_next;
      r_n       <= w_n_next;
      r_err     <= w_err_next;
      r_cnt     <= w_cnt_next;
      r_pw      <= w_pw_next;
      r_step    <= w_step_next;
      r_dir     <= w_dir_next;
      r_en      <= w_en_next;
      r_busy    <= w_busy_next;
      r_done    <= w_done_next;
      r_aborted <= w_aborted_next;
      r_rem     <= w_rem_next;
    end
  end

  assign bus.step      = r_step;
  assign bus.dir       = r_dir;
  assign bus.en        = r_en;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.aborted   = r_aborted;
  assign bus.remaining = r_rem;

endmodule

// File: tb/tb_motor_step_sequencer.sv
// Directed bench for motor_step_sequencer: one small instance (STEP_DIV=4,
// PULSE_W=2) for functional moves, one fast instance (STEP_DIV=2, PULSE_W=1)
// for the full-length move and asynchronous reset.
module tb_motor_step_sequencer;

  localparam int A_DIV = 4;
  localparam int A_PW  = 2;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  motor_step_sequencer_if bus_a();
  motor_step_sequencer_if bus_b();

  motor_step_sequencer #(.STEP_DIV(A_DIV), .PULSE_W(A_PW)) u_dut_a (
    .clk_clk     (clk),
    .reset_reset (rst),
    .bus         (bus_a)
  );

  motor_step_sequencer #(.STEP_DIV(2), .PULSE_W(1)) u_dut_b (
    .clk_clk     (clk),
    .reset_reset (rst),
    .bus         (bus_b)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmds_a(input logic [15:0] ca, cb, cx, cy);
    bus_a.motora_cmd = ca;
    bus_a.motorb_cmd = cb;
    bus_a.motorx_cmd = cx;
    bus_a.motory_cmd = cy;
  endtask

  // Runs one move on instance A and checks every cycle from T+1 to one past done.
  // masks holds the expected step vector of major step k in bits [4k-4 +: 4].
  // chg_cyc > 0 re-issues start with different commands at that cycle.
  task automatic run_move(input string name, input logic [15:0] ca, cb, cx, cy,
                          input int n, input logic [3:0] exp_dir, exp_en,
                          input logic [63:0] masks, input int chg_cyc);
    int         done_c;
    int         e_rem;
    logic [3:0] e_step;
    set_cmds_a(ca, cb, cx, cy);
    bus_a.start = 1'b1;
    tick();
    bus_a.start = 1'b0;
    done_c = (n == 0) ? 2 : 1 + n * A_DIV + A_PW;
    for (int c = 1; c <= done_c + 1; c++) begin
      tick();
      e_step = 4'b0000;
      e_rem  = n;
      for (int k = 1; k <= n; k++) begin
        if (c >= 1 + k * A_DIV && c <= A_PW + k * A_DIV) e_step = masks[4*(k-1) +: 4];
        if (c >= 1 + k * A_DIV) e_rem--;
      end
      check_eq($sformatf("%s c%0d step", name, c), 32'(bus_a.step), 32'(e_step));
      check_eq($sformatf("%s c%0d busy", name, c), 32'(bus_a.busy), 32'(c < done_c));
      check_eq($sformatf("%s c%0d done", name, c), 32'(bus_a.done), 32'(c == done_c));
      check_eq($sformatf("%s c%0d en", name, c), 32'(bus_a.en), 32'((c < done_c) ? exp_en : 4'b0000));
      check_eq($sformatf("%s c%0d dir", name, c), 32'(bus_a.dir), 32'(exp_dir));
      check_eq($sformatf("%s c%0d aborted", name, c), 32'(bus_a.aborted), 32'(0));
      if (c < done_c) check_eq($sformatf("%s c%0d remaining", name, c), 32'(bus_a.remaining), 32'(e_rem));
      if (chg_cyc > 0 && c == chg_cyc) begin
        set_cmds_a(16'h7FFF, 16'hFFFF, 16'h7FFF, 16'hFFFF);
        bus_a.start = 1'b1;
      end else begin
        bus_a.start = 1'b0;
      end
    end
    set_cmds_a(16'h0000, 16'h0000, 16'h0000, 16'h0000);
    $display("move %s n=%0d done at cycle %0d", name, n, done_c);
  endtask

  initial begin
    int         done_c;
    int         seen;
    int         cnt [4];
    logic [3:0] prev;

    rst = 1'b1;
    set_cmds_a(16'h0000, 16'h0000, 16'h0000, 16'h0000);
    bus_a.start = 1'b0;
    bus_a.abort = 1'b0;
    bus_b.motora_cmd = 16'h0000;
    bus_b.motorb_cmd = 16'h0000;
    bus_b.motorx_cmd = 16'h0000;
    bus_b.motory_cmd = 16'h0000;
    bus_b.start = 1'b0;
    bus_b.abort = 1'b0;
    tick();
    tick();
    check_eq("reset outputs A", 32'({bus_a.step, bus_a.dir, bus_a.en, bus_a.busy, bus_a.done,
                                     bus_a.aborted, bus_a.remaining}), 32'(0));
    check_eq("reset outputs B", 32'({bus_b.step, bus_b.dir, bus_b.en, bus_b.busy, bus_b.done,
                                     bus_b.aborted, bus_b.remaining}), 32'(0));
    rst = 1'b0;
    tick();
    $display("reset released");

    // Single axis: three pulses on axis 0.
    run_move("single", 16'h0003, 16'h0000, 16'h0000, 16'h0000, 3, 4'b0000, 4'b0001,
             64'h111, 0);
    // Interpolation: axis 0 every step, axis 2 on steps 1 and 3.
    run_move("interp", 16'h8004, 16'h0000, 16'h8002, 16'h0000, 4, 4'b0101, 4'b0101,
             64'h1515, 0);
    // Zero move: directions still latched, no enable, no pulses.
    run_move("zero", 16'h8000, 16'h0000, 16'h8000, 16'h0000, 0, 4'b0101, 4'b0000,
             64'h0, 0);
    // Second start plus new commands mid-move must not disturb the running move.
    run_move("restart", 16'h0002, 16'h8001, 16'h0000, 16'h0000, 2, 4'b0010, 4'b0011,
             64'h13, 3);

    // start together with abort in IDLE: nothing may happen.
    set_cmds_a(16'h0003, 16'h0000, 16'h0000, 16'h0000);
    bus_a.start = 1'b1;
    bus_a.abort = 1'b1;
    tick();
    bus_a.start = 1'b0;
    bus_a.abort = 1'b0;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (bus_a.busy || bus_a.en != 4'b0000 || bus_a.step != 4'b0000 || bus_a.done) seen++;
    end
    check_eq("start+abort idle activity", 32'(seen), 32'(0));
    $display("start+abort in idle: active cycles %0d", seen);

    // Abort during a 5-step move, just after the 2nd pulse rises.
    set_cmds_a(16'h0005, 16'h0000, 16'h0000, 16'h8003);
    bus_a.start = 1'b1;
    tick();
    bus_a.start = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (c == 1) check_eq("abort move en", 32'(bus_a.en), 32'(4'b1001));
      if (c == 1) check_eq("abort move dir", 32'(bus_a.dir), 32'(4'b1000));
      if (c == 5) check_eq("abort pulse1 step", 32'(bus_a.step), 32'(4'b1001));
      if (c == 9) check_eq("abort pulse2 step", 32'(bus_a.step), 32'(4'b0001));
    end
    bus_a.abort = 1'b1;
    tick();
    check_eq("abort step", 32'(bus_a.step), 32'(0));
    check_eq("abort en", 32'(bus_a.en), 32'(0));
    check_eq("abort busy", 32'(bus_a.busy), 32'(0));
    check_eq("abort aborted", 32'(bus_a.aborted), 32'(1));
    check_eq("abort done", 32'(bus_a.done), 32'(0));
    bus_a.abort = 1'b0;
    tick();
    check_eq("abort aborted pulse", 32'(bus_a.aborted), 32'(0));
    seen = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (bus_a.done || bus_a.busy || bus_a.step != 4'b0000) seen++;
    end
    check_eq("abort no activity after", 32'(seen), 32'(0));
    set_cmds_a(16'h0000, 16'h0000, 16'h0000, 16'h0000);
    $display("abort move: aborted after 2nd pulse");
    run_move("after_abort", 16'h0003, 16'h0000, 16'h0000, 16'h0000, 3, 4'b0000, 4'b0001,
             64'h111, 0);

    // Full-length move on the fast instance.
    bus_b.motora_cmd = 16'h7FFF;
    bus_b.motorb_cmd = 16'h7FFF;
    bus_b.motorx_cmd = 16'h7FFF;
    bus_b.motory_cmd = 16'h7FFF;
    bus_b.start = 1'b1;
    tick();
    bus_b.start = 1'b0;
    done_c = -1;
    prev = 4'b0000;
    for (int i = 0; i < 4; i++) cnt[i] = 0;
    for (int c = 1; c <= 70000 && done_c < 0; c++) begin
      tick();
      if (c == 1) check_eq("max remaining", 32'(bus_b.remaining), 32'(32767));
      for (int i = 0; i < 4; i++) begin
        if (bus_b.step[i] && !prev[i]) cnt[i]++;
      end
      prev = bus_b.step;
      if (bus_b.done) done_c = c;
    end
    check_eq("max done cycle", 32'(done_c), 32'(1 + 2 * 32767 + 1));
    for (int i = 0; i < 4; i++) check_eq($sformatf("max pulses axis%0d", i), 32'(cnt[i]), 32'(32767));
    $display("max move: done at cycle %0d pulses %0d %0d %0d %0d", done_c, cnt[0], cnt[1], cnt[2], cnt[3]);

    // Asynchronous reset in the middle of a step pulse.
    bus_b.motora_cmd = 16'h8003;
    bus_b.motorb_cmd = 16'h0000;
    bus_b.motorx_cmd = 16'h0000;
    bus_b.motory_cmd = 16'h0000;
    bus_b.start = 1'b1;
    tick();
    bus_b.start = 1'b0;
    seen = 0;
    for (int c = 0; c < 20 && seen == 0; c++) begin
      tick();
      if (bus_b.step != 4'b0000) seen = 1;
    end
    check_eq("reset test pulse seen", 32'(seen), 32'(1));
    check_eq("reset test dir before", 32'(bus_b.dir), 32'(4'b0001));
    #2;
    rst = 1'b1;
    #1;
    check_eq("async reset outputs", 32'({bus_b.step, bus_b.dir, bus_b.en, bus_b.busy, bus_b.done,
                                         bus_b.aborted, bus_b.remaining}), 32'(0));
    #1;
    rst = 1'b0;
    tick();
    tick();
    check_eq("after reset busy", 32'(bus_b.busy), 32'(0));
    check_eq("after reset step", 32'(bus_b.step), 32'(0));
    $display("async reset mid-pulse: outputs cleared");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
